// File: rtl/sh7034_itu_intc_pkg.sv
// Shared types and constants for the SH7034 ITU interrupt request stage.
package sh7034_itu_intc_pkg;

  // IPRC: upper byte not used by the ITU, ITU0/ITU1 priorities in the low byte.
  typedef struct packed {
    logic [7:0] rsvd;
    logic [3:0] itu0;
    logic [3:0] itu1;
  } IPRC_t;

  // IPRD: ITU2..ITU4 priorities, low nibble stored only.
  typedef struct packed {
    logic [3:0] itu2;
    logic [3:0] itu3;
    logic [3:0] itu4;
    logic [3:0] rsvd;
  } IPRD_t;

  localparam logic [15:0] IPRx_INIT  = 16'h0000;
  localparam logic [15:0] IPRx_WMASK = 16'hFFFF;
  localparam logic [15:0] IPRx_RMASK = 16'hFFFF;

  localparam logic [7:0]  ITU_VEC_BASE = 8'd24;
  localparam logic [27:0] INTC_ADDR    = 28'h5FFFF88;

  // ACKD lasts this many further CE_R ticks after the acknowledge edge.
  localparam logic [1:0]  ACKD_HOLD    = 2'd1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PEND = 2'd1,
    ACKD = 2'd2
  } INTC_STATE_t;

  // Source index is 3*channel + {IMIA,IMIB,OVI}; vector is base + 4*channel + kind,
  // which equals base + index + channel.
  function automatic logic [7:0] itu_vec(input logic [3:0] src_idx);
    return ITU_VEC_BASE + {4'd0, src_idx} + {4'd0, src_idx / 4'd3};
  endfunction

endpackage

// File: rtl/sh7034_intc_prio.sv
// 15-way maximum-priority selector for the ITU request lines.
// Lower source index wins ties, giving IMIA0 > IMIB0 > OVI0 > IMIA1 > ... > OVI4.
module sh7034_intc_prio (
  input  logic [14:0]     src,
  input  logic [4:0][3:0] chan_prio,
  output logic            valid,
  output logic [3:0]      level,
  output logic [3:0]      index
);

  logic       best_valid;
  logic [3:0] best_lvl;
  logic [3:0] best_idx;

  // Scan in tie-break order; only a strictly higher priority displaces the current best.
  always_comb begin
    best_valid = 1'b0;
    best_lvl   = 4'd0;
    best_idx   = 4'd0;
    for (int ch = 0; ch < 5; ch++) begin
      for (int k = 0; k < 3; k++) begin
        if (src[ch*3 + k] && (chan_prio[ch] > best_lvl)) begin
          best_valid = 1'b1;
          best_lvl   = chan_prio[ch];
          best_idx   = 4'(ch*3 + k);
        end
      end
    end
  end

  assign valid = best_valid;
  assign level = best_lvl;
  assign index = best_idx;

endmodule

// File: rtl/sh7034_itu_intc.sv
// SH7034 ITU interrupt arbiter: IPRC/IPRD register window, request sampling,
// priority resolution and the CPU request/acknowledge FSM.
//
//   state | meaning
//   IDLE  | no request presented, INT_REQ low
//   PEND  | INT_REQ high, level/vector track the current winner
//   ACKD  | CPU accepted; INT_REQ low while the ITU flag clear propagates
module sh7034_itu_intc
  import sh7034_itu_intc_pkg::*;
(
  input  logic        CLK,
  input  logic        RST,
  input  logic        CE_R,
  input  logic        CE_F,
  input  logic [4:0]  IMIA_IRQ,
  input  logic [4:0]  IMIB_IRQ,
  input  logic [4:0]  OVI_IRQ,
  input  logic [27:0] IBUS_A,
  input  logic [31:0] IBUS_DI,
  output logic [31:0] IBUS_DO,
  input  logic [3:0]  IBUS_BA,
  input  logic        IBUS_WE,
  input  logic        IBUS_REQ,
  output logic        IBUS_BUSY,
  output logic        IBUS_ACT,
  output logic        INT_REQ,
  output logic [3:0]  INT_LVL,
  output logic [7:0]  INT_VEC,
  input  logic        INT_ACK
);

  IPRC_t       iprc;
  IPRD_t       iprd;
  logic [31:0] ipr_all;
  logic [31:0] be_mask;
  logic [31:0] reg_do;
  logic        reg_sel, reg_wr, reg_rd;

  logic [14:0] src_in, src_q;
  logic        win_valid;
  logic [3:0]  win_lvl, win_idx;
  logic [7:0]  win_vec;

  INTC_STATE_t state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic        req_q, req_d;
  logic [3:0]  lvl_q, lvl_d;
  logic [7:0]  vec_q, vec_d;

  assign reg_sel = (IBUS_A[27:2] == INTC_ADDR[27:2]);
  assign reg_wr  = reg_sel & IBUS_WE & IBUS_REQ;
  assign reg_rd  = reg_sel & ~IBUS_WE & IBUS_REQ;
  assign ipr_all = {iprc, iprd};
  assign be_mask = {{8{IBUS_BA[3]}}, {8{IBUS_BA[2]}}, {8{IBUS_BA[1]}}, {8{IBUS_BA[0]}}}
                   & {IPRx_WMASK, IPRx_WMASK};

  // Byte-enabled longword write of IPRC:IPRD.
  always_ff @(posedge CLK) begin
    if (RST) begin
      iprc <= IPRC_t'(IPRx_INIT);
      iprd <= IPRD_t'(IPRx_INIT);
    end else if (CE_R && reg_wr) begin
      {iprc, iprd} <= (ipr_all & ~be_mask) | (IBUS_DI & be_mask);
    end
  end

  // Read data is captured on the falling phase so it is stable for the bus.
  always_ff @(posedge CLK) begin
    if (RST) begin
      reg_do <= 32'd0;
    end else if (CE_F && reg_rd) begin
      reg_do <= ipr_all & {IPRx_RMASK, IPRx_RMASK};
    end
  end

  assign IBUS_DO   = reg_sel ? reg_do : 32'd0;
  assign IBUS_ACT  = reg_sel;
  assign IBUS_BUSY = 1'b0;

  // Pack request lines in tie-break order: index 3n = IMIA n, 3n+1 = IMIB n, 3n+2 = OVI n.
  always_comb begin
    src_in = 15'd0;
    for (int n = 0; n < 5; n++) begin
      src_in[3*n]     = IMIA_IRQ[n];
      src_in[3*n + 1] = IMIB_IRQ[n];
      src_in[3*n + 2] = OVI_IRQ[n];
    end
  end

  // Request sample register; resolution works from this, not the raw lines.
  always_ff @(posedge CLK) begin
    if (RST) begin
      src_q <= 15'd0;
    end else if (CE_R) begin
      src_q <= src_in;
    end
  end

  sh7034_intc_prio u_prio (
    .src       (src_q),
    .chan_prio ({iprd.itu4, iprd.itu3, iprd.itu2, iprc.itu1, iprc.itu0}),
    .valid     (win_valid),
    .level     (win_lvl),
    .index     (win_idx)
  );

  assign win_vec = itu_vec(win_idx);

  // FSM state and registered CPU-facing outputs.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      cnt_q   <= 2'd0;
      req_q   <= 1'b0;
      lvl_q   <= 4'd0;
      vec_q   <= 8'd0;
    end else if (CE_R) begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      lvl_q   <= lvl_d;
      vec_q   <= vec_d;
    end
  end

  // Next state; acknowledge takes precedence over a winner disappearing.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    lvl_d   = lvl_q;
    vec_d   = vec_q;
    case (state_q)
      IDLE: begin
        req_d = 1'b0;
        if (win_valid) begin
          state_d = PEND;
          req_d   = 1'b1;
          lvl_d   = win_lvl;
          vec_d   = win_vec;
        end
      end
      PEND: begin
        if (INT_ACK) begin
          state_d = ACKD;
          req_d   = 1'b0;
          cnt_d   = ACKD_HOLD;
        end else if (!win_valid) begin
          state_d = IDLE;
          req_d   = 1'b0;
        end else begin
          lvl_d = win_lvl;
          vec_d = win_vec;
        end
      end
      ACKD: begin
        req_d = 1'b0;
        if (cnt_q == 2'd0) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      default: begin
        state_d = IDLE;
        req_d   = 1'b0;
      end
    endcase
  end

  assign INT_REQ = req_q;
  assign INT_LVL = lvl_q;
  assign INT_VEC = vec_q;

endmodule

// File: tb/tb_sh7034_itu_intc.sv
// Scoreboard bench for sh7034_itu_intc: stimulus computes expected outputs from a
// behavioural model and queues them; a monitor compares after every CE_R edge.
module tb_sh7034_itu_intc;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        CE_R = 1'b0;
  logic        CE_F = 1'b0;
  logic [4:0]  IMIA_IRQ = '0, IMIB_IRQ = '0, OVI_IRQ = '0;
  logic [27:0] IBUS_A = '0;
  logic [31:0] IBUS_DI = '0;
  logic [31:0] IBUS_DO;
  logic [3:0]  IBUS_BA = '0;
  logic        IBUS_WE = 1'b0, IBUS_REQ = 1'b0;
  logic        IBUS_BUSY, IBUS_ACT;
  logic        INT_REQ;
  logic [3:0]  INT_LVL;
  logic [7:0]  INT_VEC;
  logic        INT_ACK = 1'b0;

  sh7034_itu_intc dut (
    .CLK(CLK), .RST(RST), .CE_R(CE_R), .CE_F(CE_F),
    .IMIA_IRQ(IMIA_IRQ), .IMIB_IRQ(IMIB_IRQ), .OVI_IRQ(OVI_IRQ),
    .IBUS_A(IBUS_A), .IBUS_DI(IBUS_DI), .IBUS_DO(IBUS_DO), .IBUS_BA(IBUS_BA),
    .IBUS_WE(IBUS_WE), .IBUS_REQ(IBUS_REQ), .IBUS_BUSY(IBUS_BUSY), .IBUS_ACT(IBUS_ACT),
    .INT_REQ(INT_REQ), .INT_LVL(INT_LVL), .INT_VEC(INT_VEC), .INT_ACK(INT_ACK)
  );

  always #5 CLK = ~CLK;

  // Alternate rising-phase and falling-phase enables on successive clock edges.
  always @(negedge CLK) begin
    CE_R <= ~CE_R;
    CE_F <= CE_R;
  end

  typedef struct {
    logic        req;
    logic [3:0]  lvl;
    logic [7:0]  vec;
    logic [31:0] dout;
    logic        act;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  logic [27:0] win_addr = 28'h5FFFF88;

  // Reference model state
  logic [31:0] m_ipr = '0;
  logic [4:0]  m_a = '0, m_b = '0, m_o = '0;
  logic        m_req = 1'b0;
  logic [3:0]  m_lvl = '0;
  logic [7:0]  m_vec = '0;
  int          m_quiet = 0;
  logic [31:0] m_rdo = '0;

  // Highest priority wins; among equals the earliest in IMIA0,IMIB0,OVI0,IMIA1,... order.
  function automatic void resolve(input logic [31:0] ipr, input logic [4:0] a, input logic [4:0] b,
                                  input logic [4:0] o, output bit found, output logic [3:0] lvl,
                                  output logic [7:0] vec);
    int best = -1;
    found = 0;
    lvl   = '0;
    vec   = '0;
    for (int ch = 0; ch < 5; ch++) begin
      int pr;
      logic [2:0] lines;
      pr = int'((ipr >> (20 - 4*ch)) & 32'hF);
      lines = {o[ch], b[ch], a[ch]};
      for (int k = 0; k < 3; k++) begin
        if (lines[k] && pr != 0) begin
          int key;
          key = pr*64 - (ch*3 + k);
          if (key > best) begin
            best  = key;
            found = 1;
            lvl   = 4'(pr);
            vec   = 8'(24 + 4*ch + k);
          end
        end
      end
    end
  endfunction

  // One CE_R tick: drive inputs mid-cycle, advance the model, queue the expectation.
  // op: 0 idle, 1 write, 2 read.
  task automatic step(input bit rst, input logic [4:0] a, input logic [4:0] b, input logic [4:0] o,
                      input bit ack, input int op, input logic [27:0] addr,
                      input logic [31:0] data, input logic [3:0] ba);
    bit         sel, wr, rd, found;
    logic [3:0] l;
    logic [7:0] v;
    exp_t       e;
    do @(posedge CLK); while (!CE_R);
    @(negedge CLK);
    RST      = rst;
    IMIA_IRQ = a;
    IMIB_IRQ = b;
    OVI_IRQ  = o;
    INT_ACK  = ack;
    IBUS_A   = addr;
    IBUS_DI  = data;
    IBUS_BA  = ba;
    IBUS_WE  = (op == 1);
    IBUS_REQ = (op != 0);
    sel = (addr[27:2] == win_addr[27:2]);
    wr  = sel && (op == 1);
    rd  = sel && (op == 2);
    if (rst) begin
      m_ipr = '0; m_a = '0; m_b = '0; m_o = '0;
      m_req = 0; m_lvl = '0; m_vec = '0; m_quiet = 0; m_rdo = '0;
    end else begin
      if (rd) m_rdo = m_ipr;
      if (m_quiet > 0) begin
        m_quiet--;
        m_req = 0;
      end else if (m_req && ack) begin
        m_req   = 0;
        m_quiet = 2;
      end else begin
        resolve(m_ipr, m_a, m_b, m_o, found, l, v);
        if (found) begin
          m_req = 1; m_lvl = l; m_vec = v;
        end else begin
          m_req = 0;
        end
      end
      m_a = a; m_b = b; m_o = o;
      if (wr) begin
        for (int i = 0; i < 4; i++)
          if (ba[i]) m_ipr[8*i +: 8] = data[8*i +: 8];
      end
    end
    e.req  = m_req;
    e.lvl  = m_lvl;
    e.vec  = m_vec;
    e.dout = sel ? m_rdo : 32'd0;
    e.act  = sel;
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n);
    repeat (n) step(0, 5'd0, 5'd0, 5'd0, 0, 0, 28'd0, 32'd0, 4'd0);
  endtask

  task automatic wr_ipr(input logic [31:0] d);
    step(0, 5'd0, 5'd0, 5'd0, 0, 1, win_addr, d, 4'hF);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: after each CE_R edge, compare the DUT against the oldest queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge CLK);
      if (CE_R) begin
        #1;
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("int_req", 32'(INT_REQ), 32'(e.req));
          chk("int_lvl", 32'(INT_LVL), 32'(e.lvl));
          chk("int_vec", 32'(INT_VEC), 32'(e.vec));
          chk("ibus_do", IBUS_DO, e.dout);
          chk("ibus_act", 32'(IBUS_ACT), 32'(e.act));
          chk("ibus_busy", 32'(IBUS_BUSY), 32'd0);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) step(1, 5'd0, 5'd0, 5'd0, 0, 0, 28'd0, 32'd0, 4'd0);
    idle(1);

    // ITU0 priority 5, IMIA0 held
    wr_ipr(32'h0050_0000);
    repeat (4) step(0, 5'b00001, 5'd0, 5'd0, 0, 0, 28'd0, 32'd0, 4'd0);
    idle(2);

    // ITU0=3, ITU2=9: OVI2 beats IMIA0, then drops
    wr_ipr(32'h0030_9000);
    repeat (3) step(0, 5'b00001, 5'd0, 5'b00100, 0, 0, 28'd0, 32'd0, 4'd0);
    repeat (3) step(0, 5'b00001, 5'd0, 5'd0, 0, 0, 28'd0, 32'd0, 4'd0);
    idle(2);

    // Equal priority tie: IMIB0 over IMIA1
    wr_ipr(32'h0077_0000);
    repeat (3) step(0, 5'b00010, 5'b00001, 5'd0, 0, 0, 28'd0, 32'd0, 4'd0);
    idle(2);

    // Acknowledge with source held, then re-request
    wr_ipr(32'h0050_0000);
    repeat (3) step(0, 5'b00001, 5'd0, 5'd0, 0, 0, 28'd0, 32'd0, 4'd0);
    step(0, 5'b00001, 5'd0, 5'd0, 1, 0, 28'd0, 32'd0, 4'd0);
    repeat (5) step(0, 5'b00001, 5'd0, 5'd0, 0, 0, 28'd0, 32'd0, 4'd0);

    // Acknowledge in the same tick the winner drops
    step(0, 5'd0, 5'd0, 5'd0, 0, 0, 28'd0, 32'd0, 4'd0);
    step(0, 5'd0, 5'd0, 5'd0, 1, 0, 28'd0, 32'd0, 4'd0);
    idle(4);

    // All priorities zero: nothing eligible
    wr_ipr(32'h0000_0000);
    repeat (4) step(0, 5'h1F, 5'h1F, 5'h1F, 1, 0, 28'd0, 32'd0, 4'd0);
    idle(2);

    // Register readback and out-of-window read
    wr_ipr(32'h1234_5678);
    step(0, 5'd0, 5'd0, 5'd0, 0, 2, win_addr, 32'd0, 4'hF);
    step(0, 5'd0, 5'd0, 5'd0, 0, 2, win_addr, 32'd0, 4'hF);
    step(0, 5'd0, 5'd0, 5'd0, 0, 2, win_addr + 28'd4, 32'd0, 4'hF);
    step(0, 5'd0, 5'd0, 5'd0, 0, 1, win_addr, 32'hFFFF_FFFF, 4'b0101);
    step(0, 5'd0, 5'd0, 5'd0, 0, 2, win_addr + 28'd2, 32'd0, 4'hF);
    step(0, 5'd0, 5'd0, 5'd0, 0, 0, win_addr, 32'd0, 4'hF);

    // Reset during PEND
    wr_ipr(32'h00F0_0000);
    repeat (3) step(0, 5'b00001, 5'd0, 5'd0, 0, 0, 28'd0, 32'd0, 4'd0);
    step(1, 5'b00001, 5'd0, 5'd0, 0, 0, 28'd0, 32'd0, 4'd0);
    repeat (3) step(0, 5'b00001, 5'd0, 5'd0, 0, 0, 28'd0, 32'd0, 4'd0);

    // Randomized traffic
    for (int i = 0; i < 700; i++) begin
      bit          r_rst, r_ack;
      int          op, sel_kind;
      logic [27:0] addr;
      r_rst = ($urandom_range(0, 99) == 0);
      r_ack = ($urandom_range(0, 3) == 0);
      op    = $urandom_range(0, 9);
      op    = (op == 0) ? 1 : (op == 1) ? 2 : 0;
      sel_kind = $urandom_range(0, 3);
      addr  = (sel_kind == 0) ? 28'($urandom) : win_addr + 28'($urandom_range(0, 3));
      step(r_rst,
           5'($urandom) & 5'($urandom),
           5'($urandom) & 5'($urandom),
           5'($urandom) & 5'($urandom),
           r_ack, op, addr, $urandom, 4'($urandom));
    end

    idle(3);
    repeat (2) begin
      do @(posedge CLK); while (!CE_R);
    end
    #2;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
